// File: rtl/sp_ram_bist_pkg.sv
// Shared types and LFSR step for the sp_ram BIST engine.
// The inverted second pass states exist only with SP_RAM_BIST_INV_PASS_EN.
package sp_ram_bist_pkg;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
`ifdef SP_RAM_BIST_INV_PASS_EN
    , ST_WRITE_INV,
    ST_READ_INV,
    ST_DRAIN_INV
`endif
  } state_e;

  // 32-bit Galois LFSR, right shift
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/sp_ram_bist_if.sv
// Port bundle between the BIST engine (master) and the RAM under test (slave).
interface sp_ram_bist_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] ram_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  modport master (output ram_data, ram_addr, ram_we, input  ram_q);
  modport slave  (input  ram_data, ram_addr, ram_we, output ram_q);
endinterface

// File: rtl/sp_ram_bist_lfsr.sv
// Pattern LFSR: val_o is the word for the access issued this cycle; load
// restarts the sequence at the seed, load/en step the register past it.
module sp_ram_bist_lfsr
  import sp_ram_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        en_i,
  output logic [31:0] val_o
);
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] lfsr_q;

  assign val_o = load_i ? SEED_EFF : lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               lfsr_q <= SEED_EFF;
    else if (load_i || en_i)  lfsr_q <= lfsr_next(val_o);
  end
endmodule

// File: rtl/sp_ram_bist.sv
// March-style write/readback BIST for sp_ram with LFSR data and error capture.
// Define SP_RAM_BIST_INV_PASS_EN to add a second pass using inverted data.
module sp_ram_bist
  import sp_ram_bist_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter int          LAST_ADDR  = 31,
  parameter int          RD_LAT     = 1,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  sp_ram_bist_if.master         ram
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
  localparam int                    CW   = $clog2(RD_LAT + 1) + 1;
  localparam logic [CW-1:0]   DRAIN_END  = CW'(RD_LAT);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, fail_q, fail_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, pat;
  logic                  we_q, we_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]           err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           lfsr_val;
  logic                  lfsr_load, lfsr_en, accept, wr_ph, rd_ph, inv;
  logic                  at_last, drain_end, issue_rd, mism;

  // expected word/address travel with the read until ram_q is due
  logic [RD_LAT:0]                 vld_pipe;
  logic [RD_LAT:0][DATA_WIDTH-1:0] exp_pipe;
  logic [RD_LAT:0][ADDR_WIDTH-1:0] adr_pipe;

  assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign at_last   = (addr_q == LAST);
  assign drain_end = (cnt_q == DRAIN_END);

`ifdef SP_RAM_BIST_INV_PASS_EN
  assign wr_ph     = (state_q == ST_WRITE) || (state_q == ST_WRITE_INV);
  assign rd_ph     = (state_q == ST_READ)  || (state_q == ST_READ_INV);
  assign inv       = (state_q == ST_DRAIN) || (state_q == ST_WRITE_INV) || (state_q == ST_READ_INV);
  assign lfsr_load = accept || (wr_ph && at_last) || ((state_q == ST_DRAIN) && drain_end);
`else
  assign wr_ph     = (state_q == ST_WRITE);
  assign rd_ph     = (state_q == ST_READ);
  assign inv       = 1'b0;
  assign lfsr_load = accept || (wr_ph && at_last);
`endif
  assign lfsr_en   = (wr_ph || rd_ph) && !at_last;
  assign pat       = inv ? ~lfsr_val[DATA_WIDTH-1:0] : lfsr_val[DATA_WIDTH-1:0];

  sp_ram_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (lfsr_load),
    .en_i   (lfsr_en),
    .val_o  (lfsr_val)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    cnt_d    = cnt_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    issue_rd = 1'b0;

    mism = vld_pipe[RD_LAT] && (ram.ram_q != exp_pipe[RD_LAT]);
    if (mism) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0)    fail_d = adr_pipe[RD_LAT];
    end

    // the last write is followed directly by the read of address 0
    if (wr_ph) begin
      we_d     = !at_last;
      addr_d   = at_last ? '0 : addr_q + 1'b1;
      data_d   = pat;
      issue_rd = at_last;
    end
    if (rd_ph && !at_last) begin
      addr_d   = addr_q + 1'b1;
      data_d   = pat;
      issue_rd = 1'b1;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        state_d = ST_WRITE;
        addr_d  = '0;
        data_d  = pat;
        we_d    = 1'b1;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        err_d   = 16'd0;
        fail_d  = '0;
      end
      ST_WRITE: if (at_last) state_d = ST_READ;
      ST_READ:  if (at_last) begin
        state_d = ST_DRAIN;
        cnt_d   = '0;
      end
      ST_DRAIN: if (drain_end) begin
`ifdef SP_RAM_BIST_INV_PASS_EN
        state_d = ST_WRITE_INV;
        addr_d  = '0;
        data_d  = pat;
        we_d    = 1'b1;
`else
        state_d = ST_DONE;
        done_d  = 1'b1;
        pass_d  = (err_d == 16'd0);
`endif
      end else cnt_d = cnt_q + 1'b1;
`ifdef SP_RAM_BIST_INV_PASS_EN
      ST_WRITE_INV: if (at_last) state_d = ST_READ_INV;
      ST_READ_INV:  if (at_last) begin
        state_d = ST_DRAIN_INV;
        cnt_d   = '0;
      end
      ST_DRAIN_INV: if (drain_end) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        pass_d  = (err_d == 16'd0);
      end else cnt_d = cnt_q + 1'b1;
`endif
      default: state_d = ST_IDLE;
    endcase

    busy_d = !(state_d == ST_IDLE || state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 16'd0;
      fail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      exp_pipe <= '0;
      adr_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:0], issue_rd};
      exp_pipe <= {exp_pipe[RD_LAT-1:0], pat};
      adr_pipe <= {adr_pipe[RD_LAT-1:0], addr_d};
    end
  end

  assign ram.ram_data = data_q;
  assign ram.ram_addr = addr_q;
  assign ram.ram_we   = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign fail_addr    = fail_q;

endmodule

// File: tb/tb_sp_ram_bist.sv
// Bench for sp_ram_bist: behavioural RAM with fault hooks, timeline model, directed tests.
module tb_sp_ram_bist;
  localparam int          DW   = 32;
  localparam int          AW   = 10;
  localparam int          LAST = 31;
  localparam int          RDL  = 1;
  localparam logic [31:0] SEED = 32'h1;
  localparam int          N    = LAST + 1;
  localparam int          P    = 2 * N + RDL + 1;
`ifdef SP_RAM_BIST_INV_PASS_EN
  localparam int NPASS = 2;
  localparam int TDONE_LIT = 132;
  localparam int ERR_C_LIT = 3;
`else
  localparam int NPASS = 1;
  localparam int TDONE_LIT = 66;
  localparam int ERR_C_LIT = 2;
`endif
  localparam int TDONE = NPASS * P;

  logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] fail_addr;

  sp_ram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram ();

  sp_ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_ADDR(LAST), .RD_LAT(RDL), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .ram(ram)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference pattern straight from the LFSR recurrence
  logic [31:0] pat [N];
  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  // behavioural sp_ram: synchronous write, one-cycle read, fault hooks
  bit flip5 = 0, stuck20 = 0, invflt = 0;
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] q_raw = '0, wr_val;
  logic [AW-1:0] rd_a = '0;
  logic          rd_we = 1'b0, flip;
  int            edge_n = 0, m_t0 = 0, m_mode = 0;  // mode: 0 reset/idle, 1 running, 2 done
  bit            m_f5 = 0, m_s20 = 0, m_inv = 0;

  always_comb begin
    wr_val = ram.ram_data;
    if (stuck20 && ram.ram_addr == 10'd20) wr_val[7] = ~pat[20][7];
  end
  always @(posedge clk) begin
    if (ram.ram_we) mem[ram.ram_addr] <= wr_val;
    q_raw <= mem[ram.ram_addr];
    rd_a  <= ram.ram_addr;
    rd_we <= ram.ram_we;
  end
  assign flip = !rd_we && ((flip5 && rd_a == 10'd5) ||
                (invflt && rd_a == 10'd9 && m_mode == 1 && (edge_n - m_t0) > P));
  assign ram.ram_q = q_raw ^ {{(DW-1){1'b0}}, flip};

  // timeline model: edge index of the accepted start and the test's fault set
  always @(posedge clk) edge_n <= edge_n + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_mode <= 0;
    else if (m_mode != 1 && start) begin
      m_mode <= 1; m_t0 <= edge_n + 1;
      m_f5 <= flip5; m_s20 <= stuck20; m_inv <= invflt;
    end else if (m_mode == 1 && edge_n + 1 - m_t0 == TDONE) m_mode <= 2;
  end

  function automatic bit bad(input int p, input int a);
    return (m_f5 && a == 5) || (m_s20 && a == 20 && p == 0) || (m_inv && a == 9 && p == 1);
  endfunction

  always @(negedge clk) begin
    int t, k, p, e_err, e_fail;
    if (m_mode == 0) begin
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_pass", 32'(pass), 32'd0);
      chk("idle_err",  32'(err_count), 32'd0);
      chk("idle_fail", 32'(fail_addr), 32'd0);
      chk("idle_we",   32'(ram.ram_we), 32'd0);
      chk("idle_addr", 32'(ram.ram_addr), 32'd0);
      chk("idle_data", 32'(ram.ram_data), 32'd0);
    end else begin
      t = (m_mode == 1) ? edge_n - m_t0 : TDONE;
      e_err = 0; e_fail = 0;
      for (int pp = 0; pp < NPASS; pp++)
        for (int j = 0; j < N; j++)
          if (pp * P + N + j + RDL + 1 <= t && bad(pp, j)) begin
            if (e_err == 0) e_fail = j;
            e_err++;
          end
      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("done", 32'(done), 32'(m_mode == 2));
      chk("pass", 32'(pass), 32'(m_mode == 2 && e_err == 0));
      chk("err_count", 32'(err_count), 32'(e_err));
      chk("fail_addr", 32'(fail_addr), 32'(e_fail));
      if (m_mode == 1) begin
        p = t / P; k = t % P;
        if (k < N) begin
          chk("wr_we", 32'(ram.ram_we), 32'd1);
          chk("wr_addr", 32'(ram.ram_addr), 32'(k));
          chk("wr_data", 32'(ram.ram_data), (p == 0) ? pat[k] : ~pat[k]);
        end else begin
          chk("rd_we", 32'(ram.ram_we), 32'd0);
          if (k < 2 * N) chk("rd_addr", 32'(ram.ram_addr), 32'(k - N));
        end
      end else chk("done_we", 32'(ram.ram_we), 32'd0);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        t = edge_n - m_t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int t;
    pat[0] = SEED;
    for (int k = 1; k < N; k++) pat[k] = step(pat[k-1]);

    #1 rst_n = 1'b0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err_count), 32'd0);
    chk("rst_we",   32'(ram.ram_we), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // clean run, with a start pulse at edge 30 that must be ignored
    pulse_start();
    chk("d0", ram.ram_data, 32'h00000001);
    @(negedge clk) chk("d1", ram.ram_data, 32'h80200003);
    @(negedge clk) chk("d2", ram.ram_data, 32'hC0300002);
    repeat (27) @(negedge clk);
    pulse_start();
    chk("busy_at30", 32'(busy), 32'd1);
    wait_done(t);
    chk("done_edge_a", 32'(t), 32'(TDONE_LIT));
    chk("pass_a", 32'(pass), 32'd1);
    chk("err_a", 32'(err_count), 32'd0);
    chk("fail_a", 32'(fail_addr), 32'd0);

    // back-to-back start on the edge after done
    pulse_start();
    chk("b2b_done_clr", 32'(done), 32'd0);
    wait_done(t);
    chk("done_edge_b", 32'(t), 32'(TDONE_LIT));
    chk("pass_b", 32'(pass), 32'd1);

    // bit flip on reads of address 5, stuck bit in address 20
    repeat (3) @(negedge clk);
    flip5 = 1; stuck20 = 1;
    pulse_start();
    wait_done(t);
    chk("done_edge_c", 32'(t), 32'(TDONE_LIT));
    chk("err_c", 32'(err_count), 32'(ERR_C_LIT));
    chk("fail_c", 32'(fail_addr), 32'd5);
    chk("pass_c", 32'(pass), 32'd0);
    flip5 = 0; stuck20 = 0;

    // async reset in the middle of the read phase, then a clean run
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_pass", 32'(pass), 32'd0);
    chk("mid_rst_err",  32'(err_count), 32'd0);
    chk("mid_rst_fail", 32'(fail_addr), 32'd0);
    chk("mid_rst_we",   32'(ram.ram_we), 32'd0);
    chk("mid_rst_addr", 32'(ram.ram_addr), 32'd0);
    chk("mid_rst_data", 32'(ram.ram_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_done(t);
    chk("done_edge_d", 32'(t), 32'(TDONE_LIT));
    chk("pass_d", 32'(pass), 32'd1);
    chk("err_d", 32'(err_count), 32'd0);

`ifdef SP_RAM_BIST_INV_PASS_EN
    // single fault only visible in the inverted pass
    repeat (2) @(negedge clk);
    invflt = 1;
    pulse_start();
    repeat (66) @(negedge clk);
    chk("inv_d0", ram.ram_data, 32'hFFFFFFFE);
    chk("inv_we", 32'(ram.ram_we), 32'd1);
    wait_done(t);
    chk("done_edge_e", 32'(t), 32'd132);
    chk("err_e", 32'(err_count), 32'd1);
    chk("fail_e", 32'(fail_addr), 32'd9);
    chk("pass_e", 32'(pass), 32'd0);
    invflt = 0;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
